// File: rtl/uart_tx_sched.sv
// SFR-mapped UART transmit scheduler: buffers CPU bytes in a FIFO and feeds
// them to simpleuart one frame at a time, with a status SFR and sticky irq.
module uart_tx_sched #(
    parameter logic [7:0]  SFR_DATA_ADDR = 8'h99,
    parameter logic [7:0]  SFR_STAT_ADDR = 8'h98,
    parameter int unsigned FIFO_AW       = 3
) (
    input  logic                 iclk,
    input  logic                 rst,
    input  logic                 ram_wr_en_sfr,
    input  logic [7:0]           ram_wr_addr,
    input  logic [7:0]           ram_wr_byte,
    input  logic                 ram_rd_en_sfr,
    input  logic [7:0]           ram_rd_addr,
    output logic [7:0]           ram_rd_byte,
    input  logic [1:0]           uart_state,
    output logic                 uart_wr_en,
    output logic [7:0]           uart_wr_byte,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 irq
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t               state;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic                 tx_done;
    logic                 ovf;

    logic                 uart_idle;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_req;
    logic                 push_ok;
    logic                 push_drop;
    logic                 stat_wr;
    logic                 done_set;
    logic                 tx_done_nxt;
    logic                 ovf_nxt;
    logic [7:0]           status;

    assign fifo_count = count;

    // Datapath decode: FIFO handshake, flag set/clear, status assembly
    always_comb begin
        uart_idle   = (uart_state == 2'd0);
        fifo_empty  = (count == '0);
        fifo_full   = (count == CW'(DEPTH));
        pop         = (state == ST_IDLE) && !fifo_empty && uart_idle;
        push_req    = ram_wr_en_sfr && (ram_wr_addr == SFR_DATA_ADDR);
        push_ok     = push_req && (!fifo_full || pop);
        push_drop   = push_req && !push_ok;
        stat_wr     = ram_wr_en_sfr && (ram_wr_addr == SFR_STAT_ADDR);
        done_set    = (state == ST_WAIT_DONE) && uart_idle && fifo_empty;
        // A set event in the same cycle as a clear wins
        tx_done_nxt = done_set  || (tx_done && !(stat_wr && ram_wr_byte[4]));
        ovf_nxt     = push_drop || (ovf     && !(stat_wr && ram_wr_byte[3]));
        status      = {3'b000, tx_done, ovf, (state != ST_IDLE), fifo_empty, fifo_full};

        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge iclk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= ram_wr_byte;
        end
    end

    // Control state, pointers, flags and registered outputs
    always_ff @(posedge iclk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            uart_wr_en   <= 1'b0;
            uart_wr_byte <= 8'h00;
            ram_rd_byte  <= 8'h00;
            ovf          <= 1'b0;
            tx_done      <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            count   <= count_nxt;
            tx_done <= tx_done_nxt;
            ovf     <= ovf_nxt;
            irq     <= tx_done_nxt || ovf_nxt;

            if (ram_rd_en_sfr) begin
                ram_rd_byte <= (ram_rd_addr == SFR_STAT_ADDR) ? status : 8'h00;
            end

            uart_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        uart_wr_byte <= mem[rd_ptr];
                        uart_wr_en   <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!uart_idle) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (uart_idle) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized
// traffic against a queue-based transaction model of the scheduler.
module tb_uart_tx_sched;

    logic       iclk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_byte;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_byte;
    logic [1:0] ustate;
    logic       uart_wr_en;
    logic [7:0] uart_wr_byte;
    logic [3:0] fifo_count;
    logic       irq;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_sched dut (
        .iclk          (iclk),
        .rst           (rst),
        .ram_wr_en_sfr (wr_en),
        .ram_wr_addr   (wr_addr),
        .ram_wr_byte   (wr_byte),
        .ram_rd_en_sfr (rd_en),
        .ram_rd_addr   (rd_addr),
        .ram_rd_byte   (rd_byte),
        .uart_state    (ustate),
        .uart_wr_en    (uart_wr_en),
        .uart_wr_byte  (uart_wr_byte),
        .fifo_count    (fifo_count),
        .irq           (irq)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: byte queue plus a frame tracker
    logic [7:0] q[$];
    bit         m_frame;      // a frame is in flight
    bit         m_just_sent;  // strobe cycle of the current frame
    bit         m_uart_seen;  // UART has gone busy for this frame
    bit         m_done, m_ovf, m_irq, m_wr_en;
    logic [7:0] m_wr_byte, m_rd;

    task automatic model_step();
        logic [7:0] st;
        logic [7:0] head;
        bit         send, drop, finish;
        int         n;
        if (rst) begin
            q.delete();
            m_frame = 0; m_just_sent = 0; m_uart_seen = 0;
            m_done = 0; m_ovf = 0; m_irq = 0; m_wr_en = 0;
            m_wr_byte = 8'h00; m_rd = 8'h00;
            return;
        end
        n      = q.size();
        st     = {3'b000, m_done, m_ovf, m_frame, n == 0, n == 8};
        send   = !m_frame && n != 0 && ustate == 2'd0;
        finish = m_frame && !m_just_sent && m_uart_seen && ustate == 2'd0;
        drop   = 0;
        if (rd_en) m_rd = (rd_addr == 8'h98) ? st : 8'h00;
        head = (n != 0) ? q[0] : 8'h00;
        if (wr_en && wr_addr == 8'h99) begin
            if (n < 8 || send) q.push_back(wr_byte);
            else drop = 1;
        end
        if (send) void'(q.pop_front());
        m_wr_en = send;
        if (send) m_wr_byte = head;
        // frame progress
        if (send) begin
            m_frame = 1; m_just_sent = 1; m_uart_seen = 0;
        end else if (m_frame && m_just_sent) begin
            m_just_sent = 0;
        end else if (m_frame && !m_uart_seen) begin
            if (ustate != 2'd0) m_uart_seen = 1;
        end else if (finish) begin
            m_frame = 0;
        end
        m_done = (finish && n == 0) || (m_done && !(wr_en && wr_addr == 8'h98 && wr_byte[4]));
        m_ovf  = drop || (m_ovf && !(wr_en && wr_addr == 8'h98 && wr_byte[3]));
        m_irq  = m_done || m_ovf;
    endtask

    bit auto_uart = 0;
    int ubusy = 0;

    task automatic cycle();
        @(posedge iclk);
        model_step();
        #1;
        check("uart_wr_en",   uart_wr_en,   m_wr_en);
        check("uart_wr_byte", uart_wr_byte, m_wr_byte);
        check("fifo_count",   fifo_count,   q.size());
        check("ram_rd_byte",  rd_byte,      m_rd);
        check("irq",          irq,          m_irq);
        if (auto_uart) begin
            if (uart_wr_en) ubusy = $urandom_range(1, 12);
            ustate = (ubusy > 0) ? 2'd2 : 2'd0;
            if (ubusy > 0) ubusy--;
        end
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1; wr_addr = a; wr_byte = d;
        cycle();
        wr_en = 0;
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        rd_en = 1; rd_addr = 8'h98;
        cycle();
        rd_en = 0;
        check(tag, rd_byte, exp);
    endtask

    logic [7:0] seen[$];
    logic [7:0] exp_b[3];

    initial begin
        rst = 1; wr_en = 0; wr_addr = 0; wr_byte = 0; rd_en = 0; rd_addr = 0; ustate = 0;
        repeat (2) cycle();
        rst = 0;
        check("rst_wr_en", uart_wr_en, 1'b0);
        check("rst_count", fifo_count, 4'd0);
        read_status("rst_status", 8'h02);

        // Single frame with a 40-cycle UART busy period
        sfr_write(8'h99, 8'hA5);
        cycle();
        check("strobe_a5", uart_wr_en, 1'b1);
        check("byte_a5", uart_wr_byte, 8'hA5);
        ustate = 2;
        cycle();
        check("strobe_one_cycle", uart_wr_en, 1'b0);
        repeat (39) cycle();
        ustate = 0;
        cycle();
        check("done_irq", irq, 1'b1);
        read_status("done_status", 8'h12);

        // Three queued bytes drained in order
        ustate = 2;
        sfr_write(8'h99, 8'h11);
        sfr_write(8'h99, 8'h22);
        sfr_write(8'h99, 8'h33);
        check("three_count", fifo_count, 4'd3);
        check("three_no_strobe", uart_wr_en, 1'b0);
        auto_uart = 1; ustate = 0;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (uart_wr_en) seen.push_back(uart_wr_byte);
        end
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        check("order_n", seen.size(), 3);
        for (int i = 0; i < 3; i++) check("order_byte", (i < seen.size()) ? seen[i] : 8'hXX, exp_b[i]);
        auto_uart = 0; ustate = 2;

        // Overflow on the ninth push, then clear
        sfr_write(8'h98, 8'h18);
        for (int i = 0; i < 9; i++) sfr_write(8'h99, 8'(8'h40 + i));
        check("ovf_count", fifo_count, 4'd8);
        check("ovf_irq", irq, 1'b1);
        read_status("ovf_status", 8'h09);
        sfr_write(8'h98, 8'h08);
        check("ovf_clr_irq", irq, 1'b0);

        // Push into a full FIFO coincident with a pop
        ustate = 0;
        sfr_write(8'h99, 8'hEE);
        check("full_pop_count", fifo_count, 4'd8);
        check("full_pop_irq", irq, 1'b0);
        ustate = 2;
        repeat (3) cycle();

        // Reset in the middle of a frame
        rst = 1;
        cycle();
        rst = 0;
        check("midrst_count", fifo_count, 4'd0);
        check("midrst_wr_en", uart_wr_en, 1'b0);
        read_status("midrst_status", 8'h02);

        // Randomized traffic against the model
        auto_uart = 1; ubusy = 0; ustate = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst   = ($urandom_range(0, 399) == 0);
            wr_en = ($urandom_range(0, 2) == 0);
            r     = $urandom_range(0, 5);
            wr_addr = (r < 4) ? 8'h99 : (r == 4) ? 8'h98 : 8'($urandom);
            wr_byte = 8'($urandom);
            rd_en   = $urandom_range(0, 1) == 1;
            rd_addr = ($urandom_range(0, 1) == 1) ? 8'h98 : 8'($urandom);
            cycle();
        end
        rst = 0; wr_en = 0; rd_en = 0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
